// File: rtl/camera_stats_monitor.sv
`default_nettype none
// ============================================================================
// Module   : camera_stats_monitor
// Purpose  : Line, frame and rate statistics from camera strobes; one
//            statistic is selected by mode and latched to a display word.
// Revision : 1.0 - initial release
// ============================================================================
module camera_stats_monitor #(
    parameter int CNT_W     = 20,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        valid_byte_in,
    input  logic        tick_in,
    input  logic        capture_in,
    input  logic [2:0]  mode_in,
    output logic [31:0] display_out,
    output logic        changed_out,
    output logic        overflow_out,
    output logic        frame_done_out
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // Returns {saturated, next}; saturated only when an increment is refused.
    function automatic logic [CNT_W:0] f_sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic en);
        if (!en)
            return {1'b0, value};
        if (value == c_cnt_max)
            return {1'b1, value};
        return {1'b0, value + c_cnt_one};
    endfunction

    logic w_hs, w_vs, r_hs_q, r_vs_q;
    logic w_line_end, w_frame_start, w_latch, w_row_en;

    logic [CNT_W-1:0] r_row_cnt, r_frame_byte_cnt, r_sec_byte_cnt, r_line_cnt;
    logic [CNT_W-1:0] r_cycle_cnt, r_fs_cnt, r_frame_count, r_run_min, r_run_max;
    logic [CNT_W-1:0] r_row_bytes, r_frame_bytes, r_lines, r_row_min, r_row_max;
    logic [CNT_W-1:0] r_frame_cycles, r_fps, r_bytes_per_sec;
    logic             r_armed, r_ovf;

    logic [CNT_W-1:0] w_row_inc, w_fbyte_inc, w_sbyte_inc, w_line_inc;
    logic [CNT_W-1:0] w_cycle_inc, w_fs_inc, w_fcount_inc, w_min_next, w_max_next;
    logic             w_row_sat, w_fbyte_sat, w_sbyte_sat, w_line_sat;
    logic             w_cycle_sat, w_fs_sat, w_fcount_sat, w_sat_any;
    logic [31:0]      w_live;

    assign w_hs          = (HSYNC_POL != 0) ? hsync_in : ~hsync_in;
    assign w_vs          = (VSYNC_POL != 0) ? vsync_in : ~vsync_in;
    assign w_line_end    = r_hs_q & ~w_hs;
    assign w_frame_start = ~r_vs_q & w_vs;
    assign w_latch       = tick_in | capture_in;
    assign w_row_en      = valid_byte_in & w_hs;

    assign {w_row_sat,    w_row_inc}    = f_sat_inc(r_row_cnt, w_row_en);
    assign {w_fbyte_sat,  w_fbyte_inc}  = f_sat_inc(r_frame_byte_cnt, valid_byte_in);
    assign {w_sbyte_sat,  w_sbyte_inc}  = f_sat_inc(r_sec_byte_cnt, valid_byte_in);
    assign {w_line_sat,   w_line_inc}   = f_sat_inc(r_line_cnt, w_line_end);
    assign {w_cycle_sat,  w_cycle_inc}  = f_sat_inc(r_cycle_cnt, 1'b1);
    assign {w_fs_sat,     w_fs_inc}     = f_sat_inc(r_fs_cnt, w_frame_start);
    assign {w_fcount_sat, w_fcount_inc} = f_sat_inc(r_frame_count, w_frame_start & r_armed);

    // Counters that restart this cycle do not report their refused increment.
    assign w_sat_any = w_row_sat | w_line_sat | w_fcount_sat
                     | (~w_frame_start & (w_fbyte_sat | w_cycle_sat))
                     | (~tick_in & (w_sbyte_sat | w_fs_sat));

    // Running min/max including a line that ends this cycle.
    always_comb begin
        w_min_next = r_run_min;
        w_max_next = r_run_max;
        if (w_line_end) begin
            if (r_line_cnt == '0) begin
                w_min_next = w_row_inc;
                w_max_next = w_row_inc;
            end else begin
                if (w_row_inc < r_run_min)
                    w_min_next = w_row_inc;
                if (w_row_inc > r_run_max)
                    w_max_next = w_row_inc;
            end
        end
    end

    always_comb begin
        w_live = '0;
        case (mode_in)
            3'd0:    w_live = {r_lines[15:0], r_row_bytes[15:0]};
            3'd1:    w_live = 32'(r_bytes_per_sec);
            3'd2:    w_live = 32'(r_frame_bytes);
            3'd3:    w_live = {r_fps[15:0], r_row_bytes[15:0]};
            3'd4:    w_live = {r_row_min[15:0], r_row_max[15:0]};
            3'd5:    w_live = 32'(r_frame_cycles);
            3'd6:    w_live = {r_lines[15:0], r_fps[15:0]};
            default: w_live = {r_frame_count[15:0], 15'b0, r_armed};
        endcase
    end

    generate
        if (CNT_W > 16) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^{r_lines[CNT_W-1:16], r_row_bytes[CNT_W-1:16],
                                   r_fps[CNT_W-1:16], r_row_min[CNT_W-1:16],
                                   r_row_max[CNT_W-1:16], r_frame_count[CNT_W-1:16]};
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_hs_q           <= 1'b0;
            r_vs_q           <= 1'b0;
            r_row_cnt        <= '0;
            r_frame_byte_cnt <= '0;
            r_sec_byte_cnt   <= '0;
            r_line_cnt       <= '0;
            r_cycle_cnt      <= '0;
            r_fs_cnt         <= '0;
            r_frame_count    <= '0;
            r_run_min        <= '0;
            r_run_max        <= '0;
            r_row_bytes      <= '0;
            r_frame_bytes    <= '0;
            r_lines          <= '0;
            r_row_min        <= '0;
            r_row_max        <= '0;
            r_frame_cycles   <= '0;
            r_fps            <= '0;
            r_bytes_per_sec  <= '0;
            r_armed          <= 1'b0;
            r_ovf            <= 1'b0;
            display_out      <= '0;
            changed_out      <= 1'b0;
            overflow_out     <= 1'b0;
            frame_done_out   <= 1'b0;
        end else begin
            r_hs_q         <= w_hs;
            r_vs_q         <= w_vs;
            frame_done_out <= w_frame_start & r_armed;
            r_frame_count  <= w_fcount_inc;

            if (w_line_end) begin
                r_row_bytes <= w_row_inc;
                r_row_cnt   <= '0;
            end else begin
                r_row_cnt   <= w_row_inc;
            end

            // A line ending together with frame_start belongs to the old frame.
            if (w_frame_start) begin
                r_armed <= 1'b1;
                if (r_armed) begin
                    r_frame_bytes  <= r_frame_byte_cnt;
                    r_lines        <= w_line_inc;
                    r_row_min      <= w_min_next;
                    r_row_max      <= w_max_next;
                    r_frame_cycles <= r_cycle_cnt;
                end
                r_frame_byte_cnt <= {{(CNT_W-1){1'b0}}, valid_byte_in};
                r_line_cnt       <= '0;
                r_run_min        <= '0;
                r_run_max        <= '0;
                r_cycle_cnt      <= c_cnt_one;
            end else begin
                r_frame_byte_cnt <= w_fbyte_inc;
                r_line_cnt       <= w_line_inc;
                r_run_min        <= w_min_next;
                r_run_max        <= w_max_next;
                r_cycle_cnt      <= w_cycle_inc;
            end

            if (tick_in) begin
                r_fps           <= r_fs_cnt;
                r_bytes_per_sec <= r_sec_byte_cnt;
                r_fs_cnt        <= {{(CNT_W-1){1'b0}}, w_frame_start};
                r_sec_byte_cnt  <= {{(CNT_W-1){1'b0}}, valid_byte_in};
            end else begin
                r_fs_cnt        <= w_fs_inc;
                r_sec_byte_cnt  <= w_sbyte_inc;
            end

            if (w_latch) begin
                display_out  <= w_live;
                overflow_out <= r_ovf;
                r_ovf        <= w_sat_any;
                changed_out  <= 1'b0;
            end else begin
                r_ovf        <= r_ovf | w_sat_any;
                changed_out  <= (w_live != display_out);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_camera_stats_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_camera_stats_monitor
// Purpose  : Directed self-checking bench for camera_stats_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_camera_stats_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic       valid = 1'b0;
    logic       tick = 1'b0;
    logic       capture = 1'b0;
    logic [2:0] mode = 3'd0;

    logic [31:0] d_display, d16_display, dn_display;
    logic        d_changed, d16_changed, dn_changed;
    logic        d_overflow, d16_overflow, dn_overflow;
    logic        d_fdone, d16_fdone, dn_fdone;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    camera_stats_monitor #(.CNT_W(20), .HSYNC_POL(1), .VSYNC_POL(1)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .hsync_in(hsync), .vsync_in(vsync),
        .valid_byte_in(valid), .tick_in(tick), .capture_in(capture), .mode_in(mode),
        .display_out(d_display), .changed_out(d_changed),
        .overflow_out(d_overflow), .frame_done_out(d_fdone));

    camera_stats_monitor #(.CNT_W(16), .HSYNC_POL(1), .VSYNC_POL(1)) dut16 (
        .clk_in(clk), .rst_n_in(rst_n), .hsync_in(hsync), .vsync_in(vsync),
        .valid_byte_in(valid), .tick_in(tick), .capture_in(capture), .mode_in(mode),
        .display_out(d16_display), .changed_out(d16_changed),
        .overflow_out(d16_overflow), .frame_done_out(d16_fdone));

    camera_stats_monitor #(.CNT_W(20), .HSYNC_POL(0), .VSYNC_POL(0)) dutn (
        .clk_in(clk), .rst_n_in(rst_n), .hsync_in(~hsync), .vsync_in(~vsync),
        .valid_byte_in(valid), .tick_in(tick), .capture_in(capture), .mode_in(mode),
        .display_out(dn_display), .changed_out(dn_changed),
        .overflow_out(dn_overflow), .frame_done_out(dn_fdone));

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0; valid = 1'b0;
        tick = 1'b0; capture = 1'b0; mode = 3'd0;
        step(3);
        rst_n = 1'b1;
    endtask

    task automatic frame_pulse(output logic fd);
        vsync = 1'b1;
        step(1);
        fd = d_fdone;
        vsync = 1'b0;
        step(1);
    endtask

    task automatic send_line(input int nbytes);
        hsync = 1'b1; valid = 1'b1;
        step(nbytes);
        hsync = 1'b0; valid = 1'b0;
        step(2);
    endtask

    task automatic capture_mode(input logic [2:0] m);
        mode = m; capture = 1'b1;
        step(1);
        capture = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (d_display !== 32'h0) begin failures++; $display("FAIL reset_display: got %h expected %h", d_display, 32'h0); end
        checks++;
        if ({d_changed, d_overflow, d_fdone} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected %b", {d_changed, d_overflow, d_fdone}, 3'b000); end
        checks++;
        if ({d16_display, dn_display} !== 64'h0) begin failures++; $display("FAIL reset_variants: got %h expected %h", {d16_display, dn_display}, 64'h0); end
    endtask

    task automatic test_nominal();
        logic fd0, fd1, fd2;
        do_reset();
        frame_pulse(fd0);
        for (int l = 0; l < 4; l++) send_line(160);
        frame_pulse(fd1);
        for (int l = 0; l < 4; l++) send_line(160);
        frame_pulse(fd2);
        checks++;
        if ({fd0, fd1, fd2} !== 3'b011) begin failures++; $display("FAIL nominal_frame_done: got %b expected %b", {fd0, fd1, fd2}, 3'b011); end
        capture_mode(3'd0);
        checks++;
        if (d_display !== 32'h0004_00A0) begin failures++; $display("FAIL nominal_mode0: got %h expected %h", d_display, 32'h0004_00A0); end
        checks++;
        if (dn_display !== 32'h0004_00A0) begin failures++; $display("FAIL inverted_pol_mode0: got %h expected %h", dn_display, 32'h0004_00A0); end
        checks++;
        if (d_changed !== 1'b0) begin failures++; $display("FAIL changed_after_latch: got %b expected %b", d_changed, 1'b0); end
        mode = 3'd4;
        step(1);
        checks++;
        if (d_changed !== 1'b1) begin failures++; $display("FAIL changed_on_mode: got %b expected %b", d_changed, 1'b1); end
        checks++;
        if (d_display !== 32'h0004_00A0) begin failures++; $display("FAIL display_hold_on_mode: got %h expected %h", d_display, 32'h0004_00A0); end
        capture_mode(3'd4);
        checks++;
        if (d_display !== 32'h00A0_00A0) begin failures++; $display("FAIL nominal_mode4: got %h expected %h", d_display, 32'h00A0_00A0); end
        capture_mode(3'd2);
        checks++;
        if (d_display !== 32'd640) begin failures++; $display("FAIL nominal_frame_bytes: got %0d expected %0d", d_display, 640); end
        capture_mode(3'd5);
        checks++;
        if (d_display !== 32'd650) begin failures++; $display("FAIL nominal_frame_cycles: got %0d expected %0d", d_display, 650); end
    endtask

    task automatic test_ragged();
        logic fd;
        do_reset();
        frame_pulse(fd);
        send_line(10);
        send_line(30);
        send_line(20);
        frame_pulse(fd);
        capture_mode(3'd4);
        checks++;
        if (d_display !== 32'h000A_001E) begin failures++; $display("FAIL ragged_minmax: got %h expected %h", d_display, 32'h000A_001E); end
        capture_mode(3'd2);
        checks++;
        if (d_display !== 32'd60) begin failures++; $display("FAIL ragged_frame_bytes: got %0d expected %0d", d_display, 60); end
        capture_mode(3'd0);
        checks++;
        if (d_display !== 32'h0003_0014) begin failures++; $display("FAIL ragged_mode0: got %h expected %h", d_display, 32'h0003_0014); end
    endtask

    task automatic test_rate();
        logic fd;
        do_reset();
        tick = 1'b1; step(1); tick = 1'b0;
        for (int f = 0; f < 3; f++) frame_pulse(fd);
        valid = 1'b1; step(500); valid = 1'b0;
        // frame_start and a byte in the tick cycle belong to the next period
        tick = 1'b1; vsync = 1'b1; valid = 1'b1;
        step(1);
        fd = d_fdone;
        tick = 1'b0; vsync = 1'b0; valid = 1'b0;
        step(1);
        checks++;
        if (fd !== 1'b1) begin failures++; $display("FAIL rate_tick_frame_done: got %b expected %b", fd, 1'b1); end
        capture_mode(3'd1);
        checks++;
        if (d_display !== 32'd500) begin failures++; $display("FAIL rate_bytes_per_sec: got %0d expected %0d", d_display, 500); end
        capture_mode(3'd6);
        checks++;
        if (d_display !== 32'd3) begin failures++; $display("FAIL rate_fps: got %h expected %h", d_display, 32'd3); end
        step(3);
        tick = 1'b1; step(1); tick = 1'b0;
        capture_mode(3'd6);
        checks++;
        if (d_display !== 32'd1) begin failures++; $display("FAIL rate_tick_cycle_fps: got %h expected %h", d_display, 32'd1); end
        capture_mode(3'd1);
        checks++;
        if (d_display !== 32'd1) begin failures++; $display("FAIL rate_tick_cycle_byte: got %0d expected %0d", d_display, 1); end
    endtask

    task automatic test_saturation();
        logic fd;
        do_reset();
        frame_pulse(fd);
        send_line(70000);
        frame_pulse(fd);
        mode = 3'd0; tick = 1'b1; step(1); tick = 1'b0;
        checks++;
        if (d16_display !== 32'h0001_FFFF) begin failures++; $display("FAIL sat_row_bytes: got %h expected %h", d16_display, 32'h0001_FFFF); end
        checks++;
        if (d16_overflow !== 1'b1) begin failures++; $display("FAIL sat_overflow_set: got %b expected %b", d16_overflow, 1'b1); end
        checks++;
        if ({d_display, d_overflow} !== {32'h0001_1170, 1'b0}) begin failures++; $display("FAIL wide_no_sat: got %h/%b expected %h/%b", d_display, d_overflow, 32'h0001_1170, 1'b0); end
        step(2);
        capture_mode(3'd0);
        checks++;
        if (d16_overflow !== 1'b0) begin failures++; $display("FAIL sat_overflow_clear: got %b expected %b", d16_overflow, 1'b0); end
    endtask

    task automatic test_edge_cases();
        logic fd;
        do_reset();
        frame_pulse(fd);
        checks++;
        if (fd !== 1'b0) begin failures++; $display("FAIL first_frame_no_done: got %b expected %b", fd, 1'b0); end
        send_line(5);
        frame_pulse(fd);
        capture_mode(3'd0);
        checks++;
        if (d_display !== 32'h0001_0005) begin failures++; $display("FAIL pre_reset_frame: got %h expected %h", d_display, 32'h0001_0005); end
        send_line(9);
        do_reset();
        checks++;
        if ({d_display, d_changed, d_overflow, d_fdone} !== 35'h0) begin failures++; $display("FAIL midframe_reset: got %h expected %h", {d_display, d_changed, d_overflow, d_fdone}, 35'h0); end
        frame_pulse(fd);
        checks++;
        if (fd !== 1'b0) begin failures++; $display("FAIL post_reset_discard: got %b expected %b", fd, 1'b0); end
        send_line(7);
        frame_pulse(fd);
        checks++;
        if (fd !== 1'b1) begin failures++; $display("FAIL post_reset_done: got %b expected %b", fd, 1'b1); end
        capture_mode(3'd0);
        checks++;
        if (d_display !== 32'h0001_0007) begin failures++; $display("FAIL post_reset_frame: got %h expected %h", d_display, 32'h0001_0007); end
        checks++;
        if (dn_display !== 32'h0001_0007) begin failures++; $display("FAIL inverted_pol_post_reset: got %h expected %h", dn_display, 32'h0001_0007); end
        frame_pulse(fd);
        capture_mode(3'd4);
        checks++;
        if (d_display !== 32'h0) begin failures++; $display("FAIL empty_frame_minmax: got %h expected %h", d_display, 32'h0); end
        capture_mode(3'd0);
        checks++;
        if (d_display !== 32'h0000_0007) begin failures++; $display("FAIL empty_frame_lines: got %h expected %h", d_display, 32'h0000_0007); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_ragged();
        test_rate();
        test_saturation();
        test_edge_cases();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
